alu_sequencer: RTL



---
 rtl/alu_sequencer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: command sequencer driving an external 4-bit ALU.
// It loads the operands, runs the ALU, captures the result and presents it
// with a valid/ready handshake. A reuse command skips the operand loads.
// Optional feature macro: ALU_SEQ_MUL_EN. When it is defined, opcode 11
// (multiply) is sequenced. When it is undefined, opcode 11 is rejected
// with rsp_err.
module alu_sequencer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [1:0] cmd_op,
  input  logic       cmd_reuse,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_result,
  output logic       rsp_err,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic       alu_load1,
  output logic       alu_load2,
  output logic       alu_run,
  output logic [1:0] alu_op,
  input  logic [3:0] alu_c,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LD_A = 3'd1,
    LD_B = 3'd2,
    EXEC = 3'd3,
    CAPT = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t state, state_next;
  logic   operands_valid;
  logic   xfer;
  logic   op_blocked;
  logic   cmd_err;

`ifdef ALU_SEQ_MUL_EN
  assign op_blocked = 1'b0;
`else
  assign op_blocked = (cmd_op == 2'b11);
`endif

  // A command is accepted only in IDLE. It is rejected when it asks to
  // reuse operands that were never loaded, or when it asks for an opcode
  // that this build does not support.
  assign xfer    = cmd_valid && (state == IDLE);
  assign cmd_err = (cmd_reuse && !operands_valid) || op_blocked;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Command capture, result capture and the operands-loaded flag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      alu_a          <= '0;
      alu_b          <= '0;
      alu_op         <= '0;
      rsp_result     <= '0;
      rsp_err        <= 1'b0;
      operands_valid <= 1'b0;
    end else begin
      if (xfer) begin
        alu_a   <= cmd_a;
        alu_b   <= cmd_b;
        alu_op  <= cmd_op;
        rsp_err <= cmd_err;
      end
      if (state == CAPT) rsp_result <= alu_c;
      if (state == LD_B) operands_valid <= 1'b1;
    end
  end

  // Next-state logic and Moore outputs; the strobes are one cycle each
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    busy       = 1'b1;
    rsp_valid  = 1'b0;
    alu_load1  = 1'b0;
    alu_load2  = 1'b0;
    alu_run    = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          if (cmd_err)        state_next = DONE;
          else if (cmd_reuse) state_next = EXEC;
          else                state_next = LD_A;
        end
      end
      LD_A: begin
        alu_load1  = 1'b1;
        state_next = LD_B;
      end
      LD_B: begin
        alu_load2  = 1'b1;
        state_next = EXEC;
      end
      EXEC: begin
        alu_run    = 1'b1;
        state_next = CAPT;
      end
      CAPT: state_next = DONE;
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
